// File: rtl/sensor_trigger_gen.sv
// Row-select trigger generator: drives NUM_RS strobes in OFF, LEVEL or
// pulse-train mode. A train can optionally wait for a PA_SYNC rising edge
// before each pulse. Commands arrive one per register write.
//
// state      | meaning
// -----------+----------------------------------------------------
// IDLE       | no activity, rs low, ready for a command
// LEVEL      | rs held at mask, ready for a command
// WAIT_SYNC  | train waiting for a synchronised pa_sync rising edge
// HIGH       | pulse high phase, timer counts W_eff cycles
// LOW        | pulse low phase, timer counts the gap
module sensor_trigger_gen #(
    parameter int NUM_RS = 2,
    parameter int CW     = 16,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [NUM_RS-1:0] cmd_mask,
    input  logic [CW-1:0]     cmd_width,
    input  logic [CW-1:0]     cmd_period,
    input  logic [CNTW-1:0]   cmd_count,
    input  logic              cmd_sync,
    input  logic              abort,
    input  logic              pa_sync,
    output logic [NUM_RS-1:0] rs,
    output logic              busy,
    output logic              done,
    output logic [CNTW-1:0]   pulse_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEVEL, S_WAIT_SYNC, S_HIGH, S_LOW
    } state_t;

    localparam logic [1:0] MODE_LEVEL = 2'd1;
    localparam logic [1:0] MODE_TRAIN = 2'd2;

    logic [1:0]        rst_sync_q;
    logic              rst_int;
    logic [2:0]        sync_q;
    logic              sync_edge;

    state_t            state_q, state_d;
    logic [NUM_RS-1:0] rs_q, rs_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [CNTW-1:0]   pulse_count_q, pulse_count_d;
    logic [CW-1:0]     timer_q, timer_d;
    logic [NUM_RS-1:0] mask_q, mask_d;
    logic [CW-1:0]     w_eff_q, w_eff_d;
    logic [CW-1:0]     gap_q, gap_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic              csync_q, csync_d;

    logic              accept;
    logic [CW-1:0]     w_new;
    logic [CW-1:0]     gap_new;
    logic [CNTW-1:0]   pc_inc;
    logic              count_hit;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rst_sync_q <= 2'b11;
        else       rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst_int = rst_sync_q[1];

    // Two-flop synchroniser for pa_sync plus one flop for edge detect.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) sync_q <= 3'b000;
        else         sync_q <= {sync_q[1:0], pa_sync};
    end
    assign sync_edge = sync_q[1] & ~sync_q[2];

    assign cmd_ready = ~rst_int & ~abort & ((state_q == S_IDLE) | (state_q == S_LEVEL));
    assign accept    = cmd_valid & cmd_ready;

    assign w_new     = (cmd_width == '0) ? CW'(1) : cmd_width;
    assign gap_new   = (cmd_period > w_new) ? (cmd_period - w_new) : CW'(1);
    assign pc_inc    = (&pulse_count_q) ? pulse_count_q : pulse_count_q + CNTW'(1);
    assign count_hit = (count_q != '0) && (pulse_count_q == count_q);

    // Next-state, timer and output computation.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        pulse_count_d = pulse_count_q;
        mask_d        = mask_q;
        w_eff_d       = w_eff_q;
        gap_d         = gap_q;
        count_d       = count_q;
        csync_d       = csync_q;
        done_d        = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else if (accept) begin
            mask_d        = cmd_mask;
            w_eff_d       = w_new;
            gap_d         = gap_new;
            count_d       = cmd_count;
            csync_d       = cmd_sync;
            pulse_count_d = '0;
            case (cmd_mode)
                MODE_LEVEL: state_d = S_LEVEL;
                MODE_TRAIN: begin
                    if (cmd_sync) begin
                        state_d = S_WAIT_SYNC;
                    end else begin
                        state_d       = S_HIGH;
                        timer_d       = w_new - CW'(1);
                        pulse_count_d = CNTW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_WAIT_SYNC: begin
                    if (sync_edge) begin
                        state_d       = S_HIGH;
                        timer_d       = w_eff_q - CW'(1);
                        pulse_count_d = pc_inc;
                    end
                end
                S_HIGH: begin
                    if (timer_q == '0) begin
                        state_d = S_LOW;
                        timer_d = gap_q - CW'(1);
                    end else begin
                        timer_d = timer_q - CW'(1);
                    end
                end
                S_LOW: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - CW'(1);
                    end else if (count_hit) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (csync_q) begin
                        state_d = S_WAIT_SYNC;
                    end else begin
                        state_d       = S_HIGH;
                        timer_d       = w_eff_q - CW'(1);
                        pulse_count_d = pc_inc;
                    end
                end
                default: ;
            endcase
        end

        // rs follows the state one cycle later; abort clears it on the same edge.
        rs_d = '0;
        if (!abort && ((state_q == S_LEVEL) || (state_q == S_HIGH))) rs_d = mask_q;

        busy_d = (state_d != S_IDLE) && (state_d != S_LEVEL);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q       <= S_IDLE;
            rs_q          <= '0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            pulse_count_q <= '0;
            timer_q       <= '0;
            mask_q        <= '0;
            w_eff_q       <= CW'(1);
            gap_q         <= CW'(1);
            count_q       <= '0;
            csync_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            rs_q          <= rs_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            pulse_count_q <= pulse_count_d;
            timer_q       <= timer_d;
            mask_q        <= mask_d;
            w_eff_q       <= w_eff_d;
            gap_q         <= gap_d;
            count_q       <= count_d;
            csync_q       <= csync_d;
        end
    end

    assign rs          = rs_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pulse_count = pulse_count_q;

endmodule
